// File: rtl/intr_ctrl.sv
// Round-robin interrupt controller: edge-latched pending bits, CPU mask,
// irq/vector presentation with an ack/eoi service handshake.
module intr_ctrl #(
    parameter int NSRC = 4,
    parameter int VEC_W = 10,
    parameter logic [VEC_W-1:0] VBASE = VEC_W'(1000),
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_d,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    output logic [IW-1:0]    active_id,
    output logic             in_service,
    output logic [NSRC-1:0]  pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SERV = 2'd2;

    localparam logic [IW:0]   NS   = (IW+1)'(NSRC);
    localparam logic [IW-1:0] LAST = IW'(NSRC - 1);

    logic [1:0]       state;
    logic [NSRC-1:0]  irq_q;
    logic [NSRC-1:0]  mask;
    logic [IW-1:0]    rr_ptr;

    logic             st_idle;
    logic             st_req;
    logic             st_serv;
    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  req;
    logic [NSRC-1:0]  pend_n;
    logic             has_req;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    rr_next;
    logic [VEC_W-1:0] vec_sel;

    // First set bit of r at or above p, wrapping past the top source.
    function automatic logic [IW-1:0] rr_pick(
        input logic [NSRC-1:0] r,
        input logic [IW-1:0]   p
    );
        logic [IW:0] idx;
        logic        hit;
        rr_pick = p;
        hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            idx = {1'b0, p} + (IW+1)'(i);
            if (idx >= NS)
                idx = idx - NS;
            if (!hit && r[idx[IW-1:0]]) begin
                hit = 1'b1;
                rr_pick = idx[IW-1:0];
            end
        end
    endfunction

    assign st_idle = (state == IDLE);
    assign st_req  = (state == REQ);
    assign st_serv = (state == SERV);

    assign irq        = st_req;
    assign in_service = st_serv;

    assign rise    = irq_in & ~irq_q;
    assign req     = pending & mask;
    assign has_req = |req;
    assign sel     = rr_pick(req, rr_ptr);
    assign vec_sel = VBASE + VEC_W'(sel);
    assign rr_next = (active_id == LAST) ? '0 : active_id + IW'(1);

    // A fresh edge on the source being acked overrides the clear.
    always_comb begin
        pend_n = pending;
        if (st_req && ack)
            pend_n[active_id] = 1'b0;
        pend_n = pend_n | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            irq_q     <= '0;
            pending   <= '0;
            mask      <= '0;
            rr_ptr    <= '0;
            active_id <= '0;
            vector    <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= pend_n;
            if (mask_we)
                mask <= mask_d;
            unique case (1'b1)
                st_idle: begin
                    if (has_req) begin
                        active_id <= sel;
                        vector    <= vec_sel;
                        state     <= REQ;
                    end
                end
                st_req: begin
                    if (ack) begin
                        rr_ptr <= rr_next;
                        state  <= SERV;
                    end
                end
                st_serv: begin
                    if (eoi)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the controller.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_d = '0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq;
    logic [9:0] vector;
    logic [1:0] active_id;
    logic       in_service;
    logic [3:0] pending;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_q;
    int         m_rr;
    int         m_id;
    int         m_vec;
    bit         m_wait;
    bit         m_serv;

    intr_ctrl dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
        .mask_we(mask_we),
        .mask_d(mask_d),
        .ack(ack),
        .eoi(eoi),
        .irq(irq),
        .vector(vector),
        .active_id(active_id),
        .in_service(in_service),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = '0;
        m_mask = '0;
        m_q = '0;
        m_rr = 0;
        m_id = 0;
        m_vec = 0;
        m_wait = 0;
        m_serv = 0;
    endtask

    task automatic model_edge();
        logic [3:0] rise;
        logic [3:0] np;
        bit found;
        int s;
        rise = irq_in & ~m_q;
        np = m_pend;
        if (m_wait) begin
            if (ack) begin
                np[m_id] = 1'b0;
                m_rr = (m_id + 1) % 4;
                m_wait = 0;
                m_serv = 1;
            end
        end else if (m_serv) begin
            if (eoi)
                m_serv = 0;
        end else if ((m_pend & m_mask) != 4'b0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (!found && m_pend[s] && m_mask[s]) begin
                    found = 1;
                    m_id = s;
                end
            end
            m_vec = (1000 + m_id) % 1024;
            m_wait = 1;
        end
        if (mask_we)
            m_mask = mask_d;
        m_pend = np | rise;
        m_q = irq_in;
    endtask

    task automatic check_all();
        chk("irq", 32'(irq), 32'(m_wait));
        chk("in_service", 32'(in_service), 32'(m_serv));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("active_id", 32'(active_id), 32'(m_id));
        chk("vector", 32'(vector), 32'(m_vec));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_clear();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_irq(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (!seen) begin
                if (irq === 1'b1)
                    seen = 1;
                else
                    step();
            end
        end
        chk(tag, 32'(irq), 32'd1);
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_d = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        int exp_ids [3] = '{0, 1, 3};

        // lines high through reset count as edges on release
        irq_in = 4'hF;
        do_reset();
        step();
        chk("t1_pending", 32'(pending), 32'hF);
        chk("t1_irq", 32'(irq), 32'd0);

        // single source round trip
        irq_in = '0;
        do_reset();
        set_mask(4'hF);
        irq_in = 4'b0100;
        step();
        irq_in = '0;
        step();
        chk("t2_irq", 32'(irq), 32'd1);
        chk("t2_vector", 32'(vector), 32'd1002);
        chk("t2_id", 32'(active_id), 32'd2);
        pulse_ack();
        chk("t2_inserv", 32'(in_service), 32'd1);
        chk("t2_pend2", 32'(pending[2]), 32'd0);
        pulse_eoi();
        chk("t2_done", 32'(in_service), 32'd0);

        // round-robin order 0,1,3 then wrap back to 0
        do_reset();
        set_mask(4'hF);
        irq_in = 4'b1011;
        step();
        irq_in = '0;
        for (int n = 0; n < 3; n++) begin
            wait_irq("t3_wait");
            chk("t3_id", 32'(active_id), 32'(exp_ids[n]));
            chk("t3_vec", 32'(vector), 32'(1000 + exp_ids[n]));
            pulse_ack();
            pulse_eoi();
        end
        irq_in = 4'b1001;
        step();
        irq_in = '0;
        wait_irq("t3_wait2");
        chk("t3_wrap_id", 32'(active_id), 32'd0);

        // masked source latches but never requests
        do_reset();
        set_mask(4'b1110);
        irq_in = 4'b0001;
        step();
        irq_in = '0;
        for (int i = 0; i < 10; i++)
            step();
        chk("t4_pending", 32'(pending), 32'b0001);
        chk("t4_irq", 32'(irq), 32'd0);
        set_mask(4'hF);
        step();
        chk("t4_irq_on", 32'(irq), 32'd1);
        chk("t4_id", 32'(active_id), 32'd0);

        // re-raise during service, and edge coinciding with ack
        do_reset();
        set_mask(4'hF);
        irq_in = 4'b0010;
        step();
        irq_in = '0;
        wait_irq("t5_wait");
        pulse_ack();
        irq_in = 4'b0010;
        step();
        irq_in = '0;
        chk("t5_repend", 32'(pending[1]), 32'd1);
        pulse_eoi();
        step();
        chk("t5_reserve", 32'(irq), 32'd1);
        chk("t5_id", 32'(active_id), 32'd1);
        ack = 1'b1;
        irq_in = 4'b0010;
        step();
        ack = 1'b0;
        irq_in = '0;
        chk("t5_ackrise", 32'(pending[1]), 32'd1);

        // async reset while requesting
        pulse_eoi();
        wait_irq("t6_wait");
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("t6_irq", 32'(irq), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // random traffic against the model
        set_mask(4'hF);
        for (int c = 0; c < 600; c++) begin
            irq_in = 4'($urandom);
            mask_we = ($urandom_range(0, 7) == 0);
            mask_d = 4'($urandom);
            if (irq === 1'b1)
                ack = 1'($urandom_range(0, 1));
            else
                ack = ($urandom_range(0, 7) == 0);
            eoi = ($urandom_range(0, 3) == 0);
            step();
        end
        ack = 1'b0;
        eoi = 1'b0;
        mask_we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
